// File: rtl/switch_bounce_pkg.sv
// Shared definitions for the switch bounce generator.
//   state_e       : controller states (idle / bouncing / post-settle hold)
//   LFSR_TAPS     : Galois feedback mask for the 16-bit segment-length LFSR
//   lfsr_step     : one Galois step (right shift, xor taps when bit 0 was set)
//   lfsr_fix_seed : maps the all-zero lock-up seed to 16'h0001
package switch_bounce_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BOUNCE = 2'd1,
      ST_HOLD   = 2'd2
   } state_e;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      logic [15:0] shifted;
      shifted = s >> 1;
      return s[0] ? (shifted ^ LFSR_TAPS) : shifted;
   endfunction

   function automatic logic [15:0] lfsr_fix_seed(input logic [15:0] s);
      return (s == 16'h0000) ? 16'h0001 : s;
   endfunction

endpackage

// File: rtl/lfsr_16.sv
// 16-bit Galois LFSR used as the random source for glitch-segment lengths.
//   i_Clk   : clock, rising edge
//   i_Rst_L : asynchronous active-low reset, loads the (non-zero) seed
//   i_Adv   : advance one step this cycle
//   o_State : current LFSR state
module lfsr_16
   import switch_bounce_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        i_Clk,
   input  logic        i_Rst_L,
   input  logic        i_Adv,
   output logic [15:0] o_State
);

   localparam logic [15:0] RST_VAL = lfsr_fix_seed(SEED);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (i_Adv) begin
         lfsr_d = lfsr_step(lfsr_q);
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         lfsr_q <= RST_VAL;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign o_State = lfsr_q;

endmodule

// File: rtl/switch_bounce_gen.sv
// Mechanical switch emulator: turns a clean requested level into a bouncing
// output for a fixed window of random-length glitch segments, then holds the
// settled level for a while before accepting another change.
//   i_Clk     : clock, rising edge
//   i_Rst_L   : asynchronous active-low reset
//   i_Level   : clean requested level (synchronous to i_Clk)
//   o_Bouncy  : emulated switch contact output (registered)
//   o_Busy    : high while bouncing or holding (registered)
//   o_Settled : one-cycle pulse on the cycle the controller returns to idle
module switch_bounce_gen
   import switch_bounce_pkg::*;
#(
   parameter int unsigned BOUNCE_WINDOW = 250000,
   parameter int unsigned SEG_BITS      = 10,
   parameter int unsigned HOLD_CYCLES   = 1000,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic i_Clk,
   input  logic i_Rst_L,
   input  logic i_Level,
   output logic o_Bouncy,
   output logic o_Busy,
   output logic o_Settled
);

   localparam int unsigned WIN_W  = $clog2(BOUNCE_WINDOW + 1);
   localparam int unsigned SEG_W  = SEG_BITS + 1;
   localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

   localparam logic [WIN_W-1:0]  WIN_LOAD  = WIN_W'(BOUNCE_WINDOW);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
   localparam logic [15:0]       SEG_MASK  = 16'((32'd1 << SEG_BITS) - 32'd1);

   state_e             state_q,   state_d;
   logic               target_q,  target_d;
   logic               bouncy_q,  bouncy_d;
   logic               busy_q,    busy_d;
   logic               settled_q, settled_d;
   logic [WIN_W-1:0]   win_q,     win_d;
   logic [SEG_W-1:0]   seg_q,     seg_d;
   logic [HOLD_W-1:0]  hold_q,    hold_d;

   logic               lfsr_adv;
   logic [15:0]        lfsr_state;
   logic [15:0]        lfsr_next;
   logic [SEG_W-1:0]   seg_first;
   logic [SEG_W-1:0]   seg_reload;

   lfsr_16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .i_Adv   (lfsr_adv),
      .o_State (lfsr_state)
   );

   // The segment following an expiry must use the LFSR value after that
   // expiry's advance, so the reload length is taken from the next state.
   always_comb begin
      lfsr_next  = lfsr_step(lfsr_state);
      seg_first  = SEG_W'(lfsr_state & SEG_MASK) + SEG_W'(1);
      seg_reload = SEG_W'(lfsr_next & SEG_MASK) + SEG_W'(1);
   end

   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      bouncy_d  = bouncy_q;
      settled_d = 1'b0;
      win_d     = win_q;
      seg_d     = seg_q;
      hold_d    = hold_q;
      lfsr_adv  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_Level != target_q) begin
               target_d = i_Level;
               bouncy_d = ~bouncy_q;
               win_d    = WIN_LOAD;
               seg_d    = seg_first;
               state_d  = ST_BOUNCE;
            end else begin
               bouncy_d = target_q;
            end
         end

         ST_BOUNCE: begin
            target_d = i_Level;
            // Window end has priority over a coinciding segment expiry: the
            // output lands on the level present in this last bounce cycle
            // and the LFSR does not advance.
            if (win_q == WIN_W'(1)) begin
               bouncy_d = i_Level;
               win_d    = '0;
               seg_d    = '0;
               hold_d   = HOLD_LOAD;
               state_d  = ST_HOLD;
            end else begin
               win_d = win_q - WIN_W'(1);
               if (seg_q == SEG_W'(1)) begin
                  bouncy_d = ~bouncy_q;
                  lfsr_adv = 1'b1;
                  seg_d    = seg_reload;
               end else begin
                  seg_d = seg_q - SEG_W'(1);
               end
            end
         end

         ST_HOLD: begin
            if (hold_q == HOLD_W'(1)) begin
               hold_d    = '0;
               settled_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q   <= ST_IDLE;
         target_q  <= 1'b0;
         bouncy_q  <= 1'b0;
         busy_q    <= 1'b0;
         settled_q <= 1'b0;
         win_q     <= '0;
         seg_q     <= '0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         bouncy_q  <= bouncy_d;
         busy_q    <= busy_d;
         settled_q <= settled_d;
         win_q     <= win_d;
         seg_q     <= seg_d;
         hold_q    <= hold_d;
      end
   end

   assign o_Bouncy  = bouncy_q;
   assign o_Busy    = busy_q;
   assign o_Settled = settled_q;

endmodule
